// File: rtl/rv32im_bus_arbiter.sv
// Two-master Wishbone classic arbiter: instruction fetch (m0) and load/store (m1)
// share one slave bus, with round-robin or fixed-priority grant and a bus watchdog.
module rv32im_bus_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PRIORITY = 0,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [3:0]      m0_sel_i,
  input  logic [XLEN-3:0] m0_adr_i,
  input  logic [XLEN-1:0] m0_dat_i,
  output logic [XLEN-1:0] m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [3:0]      m1_sel_i,
  input  logic [XLEN-3:0] m1_adr_i,
  input  logic [XLEN-1:0] m1_dat_i,
  output logic [XLEN-1:0] m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [3:0]      s_sel_o,
  output logic [XLEN-3:0] s_adr_o,
  output logic [XLEN-1:0] s_dat_o,
  input  logic [XLEN-1:0] s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  localparam bit            WD_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            rr_last_q, rr_last_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [1:0]      gnt;
  logic            stb_wait;
  logic            wd_fire;

  assign gnt     = state_q;
  assign grant_o = state_q;

  assign s_cyc_o = (gnt[0] & m0_cyc_i) | (gnt[1] & m1_cyc_i);
  assign s_stb_o = (gnt[0] & m0_stb_i) | (gnt[1] & m1_stb_i);
  assign s_we_o  = (gnt[0] & m0_we_i)  | (gnt[1] & m1_we_i);
  assign s_sel_o = ({4{gnt[0]}} & m0_sel_i) | ({4{gnt[1]}} & m1_sel_i);
  assign s_adr_o = ({(XLEN-2){gnt[0]}} & m0_adr_i) | ({(XLEN-2){gnt[1]}} & m1_adr_i);
  assign s_dat_o = ({XLEN{gnt[0]}} & m0_dat_i) | ({XLEN{gnt[1]}} & m1_dat_i);

  // Watchdog fires on the TIMEOUT-th unanswered strobe cycle; a same-cycle ack wins.
  assign stb_wait  = s_stb_o & ~s_ack_i & ~s_err_i;
  assign wd_fire   = WD_EN & stb_wait & (wd_q == WD_LAST);
  assign timeout_o = wd_fire;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & gnt[0];
  assign m1_ack_o = s_ack_i & gnt[1];
  assign m0_err_o = (s_err_i | wd_fire) & gnt[0];
  assign m1_err_o = (s_err_i | wd_fire) & gnt[1];

  // Grant selection; a release hands the bus straight to a waiting master.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = ((PRIORITY != 0) || !rr_last_q) ? GNT1 : GNT0;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          rr_last_d = 1'b0;
          state_d   = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          rr_last_d = 1'b1;
          state_d   = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wd_d = wd_q + TO_W'(1);
    if ((state_d != state_q) || !stb_wait || wd_fire) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      wd_q      <= wd_d;
    end
  end

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Bench for rv32im_bus_arbiter: a round-robin and a fixed-priority instance share
// the same stimulus and are checked every cycle against a transaction-level model.
module tb_rv32im_bus_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [29:0] m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat, s_dat_in;
  logic        s_ack, s_err;

  logic [31:0] m0_dat_out [2];
  logic [31:0] m1_dat_out [2];
  logic        m0_ack [2];
  logic        m0_err [2];
  logic        m1_ack [2];
  logic        m1_err [2];
  logic        s_cyc [2];
  logic        s_stb [2];
  logic        s_we [2];
  logic [3:0]  s_sel [2];
  logic [29:0] s_adr [2];
  logic [31:0] s_dat [2];
  logic [1:0]  grant [2];
  logic        tmo [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar p = 0; p < 2; p++) begin : g_dut
    rv32im_bus_arbiter #(.XLEN(32), .PRIORITY(p), .TIMEOUT(TO), .TO_W(8)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_out[p]),
      .m0_ack_o(m0_ack[p]), .m0_err_o(m0_err[p]),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_out[p]),
      .m1_ack_o(m1_ack[p]), .m1_err_o(m1_err[p]),
      .s_cyc_o(s_cyc[p]), .s_stb_o(s_stb[p]), .s_we_o(s_we[p]), .s_sel_o(s_sel[p]),
      .s_adr_o(s_adr[p]), .s_dat_o(s_dat[p]), .s_dat_i(s_dat_in),
      .s_ack_i(s_ack), .s_err_i(s_err),
      .grant_o(grant[p]), .timeout_o(tmo[p])
    );
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  // Model: owner (0 none, 1 m0, 2 m1), last released master, unanswered-strobe count.
  int own [2];
  int last_rel [2];
  int wd [2];

  function automatic logic m_cyc(int m);
    return (m == 0) ? m0_cyc : m1_cyc;
  endfunction

  function automatic logic exp_stb(int p);
    return (own[p] == 1) ? m0_stb : (own[p] == 2) ? m1_stb : 1'b0;
  endfunction

  function automatic logic exp_fire(int p);
    return (TO != 0) && exp_stb(p) && !s_ack && !s_err && (wd[p] == int'(TO) - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int p = 0; p < 2; p++) begin
      if (!rst_n) begin
        own[p] = 0; last_rel[p] = 1; wd[p] = 0;
      end else begin
        int nxt;
        logic f, stb;
        f   = exp_fire(p);
        stb = exp_stb(p);
        nxt = own[p];
        if (own[p] == 0) begin
          if (m0_cyc && m1_cyc) nxt = (p == 1) ? 2 : ((last_rel[p] == 0) ? 2 : 1);
          else if (m0_cyc) nxt = 1;
          else if (m1_cyc) nxt = 2;
        end else if (!m_cyc(own[p] - 1)) begin
          last_rel[p] = own[p] - 1;
          nxt = m_cyc(2 - own[p]) ? (3 - own[p]) : 0;
        end
        wd[p]  = (nxt != own[p] || !stb || s_ack || s_err || f) ? 0 : wd[p] + 1;
        own[p] = nxt;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      logic g0, g1, f;
      string t;
      t  = (p == 0) ? "rr" : "fp";
      g0 = (own[p] == 1);
      g1 = (own[p] == 2);
      f  = exp_fire(p);
      chk({t, "_grant"}, grant[p], {g1, g0});
      chk({t, "_s_cyc"}, s_cyc[p], (g0 & m0_cyc) | (g1 & m1_cyc));
      chk({t, "_s_stb"}, s_stb[p], exp_stb(p));
      chk({t, "_s_we"},  s_we[p],  (g0 & m0_we) | (g1 & m1_we));
      chk({t, "_s_sel"}, s_sel[p], g0 ? m0_sel : g1 ? m1_sel : 4'h0);
      chk({t, "_s_adr"}, s_adr[p], g0 ? m0_adr : g1 ? m1_adr : 30'h0);
      chk({t, "_s_dat"}, s_dat[p], g0 ? m0_dat : g1 ? m1_dat : 32'h0);
      chk({t, "_m0_ack"}, m0_ack[p], g0 & s_ack);
      chk({t, "_m1_ack"}, m1_ack[p], g1 & s_ack);
      chk({t, "_m0_err"}, m0_err[p], g0 & (s_err | f));
      chk({t, "_m1_err"}, m1_err[p], g1 & (s_err | f));
      chk({t, "_timeout"}, tmo[p], f);
      chk({t, "_m0_dat"}, m0_dat_out[p], s_dat_in);
      chk({t, "_m1_dat"}, m1_dat_out[p], s_dat_in);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic req(input int m, input logic on);
    if (m == 0) begin m0_cyc = on; m0_stb = on; end
    else begin m1_cyc = on; m1_stb = on; end
  endtask

  initial begin
    rst_n = 1'b0;
    {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = '0;
    m0_we = 1'b0; m0_sel = 4'hf; m0_adr = 30'h123;  m0_dat = 32'h1111_2222;
    m1_we = 1'b1; m1_sel = 4'h3; m1_adr = 30'h2abc; m1_dat = 32'h3333_4444;
    s_dat_in = 32'hcafe_f00d;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_grant", grant[0], 2'b00);
    chk("rst_stb", s_stb[0], 1'b0);

    // T1: m0 alone, ack in third strobe cycle.
    req(0, 1'b1);
    tick();
    @(negedge clk);
    chk("t1_stb", s_stb[0], 1'b1);
    chk("t1_adr", s_adr[0], 30'h123);
    tick(); tick();
    s_ack = 1'b1;
    @(negedge clk);
    chk("t1_m0_ack", m0_ack[0], 1'b1);
    chk("t1_m1_ack", m1_ack[0], 1'b0);
    chk("t1_grant", grant[0], 2'b01);
    tick();
    s_ack = 1'b0; req(0, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_release", grant[0], 2'b00);

    // T2: both request out of reset; gapless handoff.
    reset_pulse();
    req(0, 1'b1); req(1, 1'b1);
    tick();
    @(negedge clk);
    chk("t2_rr_first", grant[0], 2'b01);
    chk("t2_fp_first", grant[1], 2'b10);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; req(0, 1'b0);
    tick();
    @(negedge clk);
    chk("t2_handoff", grant[0], 2'b10);
    req(0, 1'b1); s_ack = 1'b1;
    tick();
    s_ack = 1'b0; req(1, 1'b0);
    tick();
    @(negedge clk);
    chk("t2_back_to_m0", grant[0], 2'b01);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; req(0, 1'b0);
    tick(); tick();

    // T3: repeated simultaneous requests from idle.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      req(0, 1'b1); req(1, 1'b1);
      tick();
      @(negedge clk);
      chk("t3_fp_m1_wins", grant[1], 2'b10);
      chk("t3_rr_alternate", grant[0], (i % 2 == 0) ? 2'b01 : 2'b10);
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0; req(0, 1'b0); req(1, 1'b0);
      tick();
    end

    // T4: slave never answers, watchdog errs on fourth strobe cycle.
    reset_pulse();
    req(0, 1'b1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("t4_err", m0_err[0], c == 4);
      chk("t4_timeout", tmo[0], c == 4);
      tick();
    end
    req(0, 1'b0);
    tick();
    @(negedge clk);
    chk("t4_release", grant[0], 2'b00);

    // T5: ack in the fourth strobe cycle beats the watchdog.
    req(0, 1'b1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) s_ack = 1'b1;
      @(negedge clk);
      chk("t5_ack", m0_ack[0], c == 4);
      chk("t5_err", m0_err[0], 1'b0);
      chk("t5_timeout", tmo[0], 1'b0);
      tick();
    end
    s_ack = 1'b0; req(0, 1'b0);
    tick(); tick();

    // T6: asynchronous reset in the middle of a strobe.
    req(0, 1'b1);
    tick();
    @(negedge clk);
    chk("t6_stb_before", s_stb[0], 1'b1);
    #2 rst_n = 1'b0;
    req(1, 1'b1);
    #1;
    chk("t6_stb_async", s_stb[0], 1'b0);
    chk("t6_cyc_async", s_cyc[0], 1'b0);
    chk("t6_grant_async", grant[0], 2'b00);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_m0_first", grant[0], 2'b01);
    req(0, 1'b0); req(1, 1'b0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
